// File: rtl/gb_lcd_pkg.sv
// Shared Game Boy LCD geometry, capture state encoding and framebuffer write payload.
package gb_lcd_pkg;

  localparam int unsigned LCD_W  = 160;
  localparam int unsigned LCD_H  = 144;
  localparam int unsigned ADDR_W = 15;

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    ACTIVE     = 1'b1
  } cap_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        data;
  } fb_wr_t;

endpackage

// File: rtl/gb_lcd_capture_if.sv
// Raw LCD pins in, framebuffer write port out. err_sticky exists only with GB_CAPTURE_ERR_EN.
interface gb_lcd_capture_if
  import gb_lcd_pkg::*;
();

  logic              PX_CLK;
  logic              HSYNC;
  logic              VSYNC;
  logic              D0;
  logic              D1;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        wdata;
  logic              frame_done;
  logic              capturing;
`ifdef GB_CAPTURE_ERR_EN
  logic [2:0]        err_sticky;
`endif

  modport master (
    input  PX_CLK, HSYNC, VSYNC, D0, D1,
    output wen, waddr, wdata, frame_done, capturing
`ifdef GB_CAPTURE_ERR_EN
    , output err_sticky
`endif
  );

  modport slave (
    output PX_CLK, HSYNC, VSYNC, D0, D1,
    input  wen, waddr, wdata, frame_done, capturing
`ifdef GB_CAPTURE_ERR_EN
    , input err_sticky
`endif
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus one history flop; rise/fall pulses are one clk wide.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  // sh[0], sh[1]: synchroniser; sh[2]: previous synchronised level
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= 3'b000;
    else     sh <= {sh[1:0], din};
  end

  assign rise_c =  sh[1] & ~sh[2];
  assign fall_c = ~sh[1] &  sh[2];

endmodule

// File: rtl/gb_lcd_capture.sv
// Oversampling LCD pin capture producing row-major framebuffer writes.
// Optional GB_CAPTURE_ERR_EN adds sticky overrun / short-frame flags.
module gb_lcd_capture
  import gb_lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  gb_lcd_capture_if.master bus
);

  localparam logic [7:0] X_END  = 8'(LCD_W);
  localparam logic [7:0] Y_END  = 8'(LCD_H);
  localparam logic [7:0] Y_LAST = 8'(LCD_H - 1);

  logic px_fall_c, px_rise_c;
  logic hs_fall_c, hs_rise_c;
  logic vs_rise_c, vs_fall_c;

  sync_edge u_px (.clk(clk), .rst(rst), .din(bus.PX_CLK), .rise_c(px_rise_c), .fall_c(px_fall_c));
  sync_edge u_hs (.clk(clk), .rst(rst), .din(bus.HSYNC),  .rise_c(hs_rise_c), .fall_c(hs_fall_c));
  sync_edge u_vs (.clk(clk), .rst(rst), .din(bus.VSYNC),  .rise_c(vs_rise_c), .fall_c(vs_fall_c));

  logic unused_edges;
  assign unused_edges = &{1'b0, px_rise_c, hs_rise_c, vs_fall_c};

  // One stage deeper than the control path: pixel is the pin value one clk before the fall was seen
  logic [2:0] d0_pipe, d1_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_pipe <= 3'b000;
      d1_pipe <= 3'b000;
    end else begin
      d0_pipe <= {d0_pipe[1:0], bus.D0};
      d1_pipe <= {d1_pipe[1:0], bus.D1};
    end
  end

  cap_state_t        state;
  logic [7:0]        x, y;
  logic [ADDR_W-1:0] line_base;
  fb_wr_t            wr_q;
  logic              wen_q, frame_done_q, capturing_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WAIT_VSYNC;
      x            <= 8'd0;
      y            <= 8'd0;
      line_base    <= '0;
      wr_q         <= '0;
      wen_q        <= 1'b0;
      frame_done_q <= 1'b0;
      capturing_q  <= 1'b0;
    end else begin
      wen_q        <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        WAIT_VSYNC: begin
          if (vs_rise_c) begin
            state       <= ACTIVE;
            capturing_q <= 1'b1;
            x           <= 8'd0;
            y           <= 8'd0;
            line_base   <= '0;
          end
        end
        ACTIVE: begin
          // Later assignments win: line advance overrides x++, frame restart overrides both
          if (px_fall_c) begin
            if (x < X_END && y < Y_END) begin
              wen_q     <= 1'b1;
              wr_q.addr <= line_base + ADDR_W'(x);
              wr_q.data <= {d0_pipe[2], d1_pipe[2]};
            end
            if (x < X_END) x <= x + 8'd1;
          end
          if (hs_fall_c) begin
            x         <= 8'd0;
            y         <= y + 8'd1;
            line_base <= line_base + ADDR_W'(LCD_W);
            if (y == Y_LAST) begin
              frame_done_q <= 1'b1;
              state        <= WAIT_VSYNC;
              capturing_q  <= 1'b0;
            end
          end
          if (vs_rise_c) begin
            x            <= 8'd0;
            y            <= 8'd0;
            line_base    <= '0;
            frame_done_q <= 1'b0;
            state        <= ACTIVE;
            capturing_q  <= 1'b1;
          end
        end
        default: state <= WAIT_VSYNC;
      endcase
    end
  end

  assign bus.wen        = wen_q;
  assign bus.waddr      = wr_q.addr;
  assign bus.wdata      = wr_q.data;
  assign bus.frame_done = frame_done_q;
  assign bus.capturing  = capturing_q;

`ifdef GB_CAPTURE_ERR_EN
  logic [2:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 3'b000;
    end else if (state == ACTIVE) begin
      if (px_fall_c && x >= X_END)  err_q[0] <= 1'b1;
      if (hs_fall_c && y >= Y_END)  err_q[1] <= 1'b1;
      if (vs_rise_c && y < Y_LAST)  err_q[2] <= 1'b1;
    end
  end

  assign bus.err_sticky = err_q;
`endif

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Scoreboard bench for gb_lcd_capture: stimulus pushes expected writes, a monitor pops on wen.
module tb_gb_lcd_capture;
  import gb_lcd_pkg::*;

  logic clk = 1'b0;
  logic rst;

  gb_lcd_capture_if bus ();

  gb_lcd_capture dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int fd_count = 0;
  fb_wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && bus.wen === 1'b1) begin
      fb_wr_t e;
      n_wr++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wen: got addr %0d data %0d, expected no write", bus.waddr, bus.wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.waddr !== e.addr || bus.wdata !== e.data) begin
          n_fail++;
          $display("FAIL write: got addr %0d data %0d expected addr %0d data %0d",
                   bus.waddr, bus.wdata, e.addr, e.data);
        end
      end
    end
    if (!rst && bus.frame_done === 1'b1) fd_count++;
  end

  function automatic logic [1:0] pat(input int px, input int ln);
    return 2'((px + 3 * ln) & 3);
  endfunction

  // One pixel; addr < 0 means the capture must not write it
  task automatic px(input logic [1:0] d, input int addr);
    @(negedge clk);
    bus.D0 = d[1];
    bus.D1 = d[0];
    if (addr >= 0) exp_q.push_back('{addr: ADDR_W'(addr), data: d});
    repeat (2) @(negedge clk);
    bus.PX_CLK = 1'b0;
    repeat (2) @(negedge clk);
    bus.PX_CLK = 1'b1;
  endtask

  task automatic hs();
    @(negedge clk);
    bus.HSYNC = 1'b1;
    repeat (2) @(negedge clk);
    bus.HSYNC = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic vs();
    @(negedge clk);
    bus.VSYNC = 1'b1;
    repeat (2) @(negedge clk);
    bus.VSYNC = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // PX_CLK and HSYNC fall on the same clk
  task automatic px_hs(input logic [1:0] d, input int addr);
    @(negedge clk);
    bus.D0 = d[1];
    bus.D1 = d[0];
    bus.HSYNC = 1'b1;
    exp_q.push_back('{addr: ADDR_W'(addr), data: d});
    repeat (2) @(negedge clk);
    bus.PX_CLK = 1'b0;
    bus.HSYNC  = 1'b0;
    repeat (2) @(negedge clk);
    bus.PX_CLK = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.PX_CLK = 1'b1;
    bus.HSYNC  = 1'b0;
    bus.VSYNC  = 1'b0;
    bus.D0     = 1'b0;
    bus.D1     = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wen",        32'(bus.wen),        32'd0);
    chk("rst_waddr",      32'(bus.waddr),      32'd0);
    chk("rst_wdata",      32'(bus.wdata),      32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_capturing",  32'(bus.capturing),  32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Pre-sync gating
    for (int i = 0; i < 5; i++) px(2'b11, -1);
    hs();
    px(2'b10, -1);
    hs();
    drain("gate_drain");
    chk("gate_capturing", 32'(bus.capturing), 32'd0);
    chk("gate_writes", 32'(n_wr), 32'd0);

    // Frame: lines 0-1 full, remaining lines two pixels each
    vs();
    chk("frame_capturing", 32'(bus.capturing), 32'd1);
    for (int ln = 0; ln < 144; ln++) begin
      int npx;
      npx = (ln < 2) ? 160 : 2;
      for (int p = 0; p < npx; p++) px(pat(p, ln), ln * 160 + p);
      if (ln < 143) hs();
    end
    @(negedge clk);
    bus.HSYNC = 1'b1;
    repeat (2) @(negedge clk);
    bus.HSYNC = 1'b0;
    repeat (2) @(negedge clk);
    chk("fd_early", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
    chk("fd_at_3clk", 32'(bus.frame_done), 32'd1);
    @(negedge clk);
    chk("fd_single", 32'(bus.frame_done), 32'd0);
    drain("frame_drain");
    chk("frame_fd_count", 32'(fd_count), 32'd1);
    chk("frame_capturing_off", 32'(bus.capturing), 32'd0);
    px(2'b01, -1);
    drain("post_frame_drain");

    // Overrun: 165 falls on line 0, only 160 written
    vs();
    for (int p = 0; p < 165; p++) px(pat(p, 7), (p < 160) ? p : -1);
    hs();
    px(2'b10, 160);
    drain("overrun_drain");
`ifdef GB_CAPTURE_ERR_EN
    chk("err_px_overrun", 32'(bus.err_sticky[0]), 32'd1);
    chk("err_short_clear", 32'(bus.err_sticky[2]), 32'd0);
`endif

    // Coincident px/hs fall at x=159, y=5
    vs();
    for (int i = 0; i < 5; i++) hs();
    for (int p = 0; p < 159; p++) px(pat(p, 5), 800 + p);
    px_hs(2'b10, 959);
    px(2'b01, 960);
    drain("coincident_drain");

    // Mid-frame VSYNC at y=70
    vs();
    for (int i = 0; i < 70; i++) hs();
    px(2'b11, 11200);
    vs();
    px(2'b01, 0);
    drain("midframe_drain");
    chk("midframe_no_fd", 32'(fd_count), 32'd1);
`ifdef GB_CAPTURE_ERR_EN
    chk("err_short_frame", 32'(bus.err_sticky[2]), 32'd1);
    chk("err_line_overrun", 32'(bus.err_sticky[1]), 32'd0);
`endif

    // Async reset at y=40
    vs();
    for (int i = 0; i < 40; i++) hs();
    px(2'b10, 6400);
    @(negedge clk);
    bus.D0 = 1'b1;
    bus.D1 = 1'b1;
    exp_q.push_back('{addr: ADDR_W'(6401), data: 2'b11});
    repeat (2) @(negedge clk);
    bus.PX_CLK = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_wen",       32'(bus.wen),       32'd0);
    chk("arst_waddr",     32'(bus.waddr),     32'd0);
    chk("arst_wdata",     32'(bus.wdata),     32'd0);
    chk("arst_capturing", 32'(bus.capturing), 32'd0);
`ifdef GB_CAPTURE_ERR_EN
    chk("arst_err", 32'(bus.err_sticky), 32'd0);
`endif
    bus.PX_CLK = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) px(2'b11, -1);
    hs();
    px(2'b10, -1);
    drain("arst_gate_drain");
    chk("arst_wait_capturing", 32'(bus.capturing), 32'd0);
    vs();
    px(2'b01, 0);
    px(2'b10, 1);
    drain("arst_resume_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
